// File: rtl/reg_file_sb.sv
// Multi-port integer register file with prioritised writes, same-cycle read bypass
// and a per-register busy scoreboard for long-latency producers.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic [NUM_WR-1:0]          we_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wa_i,
  input  logic [NUM_WR*DATA_W-1:0]   wd_i,
  input  logic                       claim_i,
  input  logic [ADDR_W-1:0]          claim_addr_i,
  output logic [NUM_REGS-1:0]        busy_vec_o,
  output logic [CNT_W-1:0]           busy_cnt_o
);

  logic [DATA_W-1:0]   regs_q  [NUM_REGS];
  logic [DATA_W-1:0]   wr_data [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Per-register write resolution; scanning ports upward lets the highest index win.
  // Hits are suppressed while in reset so the bypass path cannot leak data out.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise the unassigned paths infer latches.
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) wr_data[r] = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (rst_ni && we_i[j] && (wa_i[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) &&
            !((ZERO_REG != 0) && (r == 0))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = wd_i[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A claim wins over a simultaneous write: the newer producer keeps the register busy.
  always_comb begin
    busy_d = '0;
    cnt_d  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_d[r] = (claim_i && (claim_addr_i == ADDR_W'(r))) | (busy_q[r] & ~wr_hit[r]);
      if ((ZERO_REG != 0) && (r == 0)) busy_d[r] = 1'b0;
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  // NOTE: the register array sits behind the async reset because the whole file
  // must read 0 immediately after reset; this is deliberate, not an oversight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_data[r];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Reads select by address compare, so out-of-range addresses and a hidden r0 fall to 0.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if ((rd_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) &&
            !((ZERO_REG != 0) && (r == 0))) begin
          rd_data_o[k*DATA_W +: DATA_W] = wr_hit[r] ? wr_data[r] : regs_q[r];
          rd_busy_o[k]                  = busy_q[r] & ~wr_hit[r];
        end
      end
    end
  end

  assign busy_vec_o = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random traffic,
// compared against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;
  localparam int CW  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NRD*AW-1:0] ra = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    we = '0;
  logic [NWR*AW-1:0] wa = '0;
  logic [NWR*DW-1:0] wd = '0;
  logic              claim = 1'b0;
  logic [AW-1:0]     caddr = '0;
  logic [NR-1:0]     busy_vec;
  logic [CW-1:0]     busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [NR];
  logic [NR-1:0] busy_m;

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(ra), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .we_i(we), .wa_i(wa), .wd_i(wd),
    .claim_i(claim), .claim_addr_i(caddr),
    .busy_vec_o(busy_vec), .busy_cnt_o(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a register file read either sees this cycle's winning write or storage.
  function automatic logic written(int a);
    if (!rst_n || a == 0) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (we[j] && int'(wa[j*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_data(int a);
    if (!rst_n || a == 0) return '0;
    for (int j = NWR - 1; j >= 0; j--)
      if (we[j] && int'(wa[j*AW +: AW]) == a) return wd[j*DW +: DW];
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(int a);
    return rst_n && (a != 0) && busy_m[a] && !written(a);
  endfunction

  task automatic model_reset();
    for (int a = 0; a < NR; a++) mem_m[a] = '0;
    busy_m = '0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] nd [NR];
    logic [NR-1:0] nb;
    nb = '0;
    for (int a = 0; a < NR; a++) begin
      nd[a] = exp_data(a);
      if (a != 0) nb[a] = (claim && int'(caddr) == a) || (busy_m[a] && !written(a));
    end
    for (int a = 1; a < NR; a++) mem_m[a] = nd[a];
    busy_m = nb;
  endtask

  task automatic check_all();
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rd_data%0d_a%0d", k, ra[k*AW +: AW]), rd_data[k*DW +: DW],
            exp_data(int'(ra[k*AW +: AW])));
      check($sformatf("rd_busy%0d_a%0d", k, ra[k*AW +: AW]), 32'(rd_busy[k]),
            32'(exp_busy(int'(ra[k*AW +: AW]))));
    end
    check("busy_vec", busy_vec, busy_m);
    check("busy_cnt", 32'(busy_cnt), 32'($countones(busy_m)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = '0;
    claim = 1'b0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
    we[j] = 1'b1;
    wa[j*AW +: AW] = AW'(a);
    wd[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int a0, input int a1);
    ra = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    model_reset();
    // Reset before any clock edge; a write in reset must not bypass.
    set_wr(0, 5, 32'h12345678);
    set_rd(5, 0);
    #1;
    check_all();
    check("reset_rd5", rd_data[31:0], 32'h0);
    check("reset_cnt", 32'(busy_cnt), 32'h0);
    idle();
    #1 rst_n = 1'b1;
    tick();

    // Write and same-cycle bypass, then storage.
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(5, 6);
    #1 check_all();
    check("bypass_r5", rd_data[31:0], 32'hDEADBEEF);
    tick();
    idle();
    #1 check_all();
    check("stored_r5", rd_data[31:0], 32'hDEADBEEF);

    // Two ports hitting the same register: port 1 wins.
    set_wr(0, 7, 32'h11111111);
    set_wr(1, 7, 32'h22222222);
    set_rd(7, 5);
    #1 check_all();
    check("conflict_byp", rd_data[31:0], 32'h22222222);
    tick();
    idle();
    #1 check_all();
    check("conflict_st", rd_data[31:0], 32'h22222222);

    // Register 0 ignores writes and claims.
    set_wr(1, 0, 32'hFFFFFFFF);
    claim = 1'b1; caddr = 5'd0;
    set_rd(0, 7);
    #1 check_all();
    check("r0_byp", rd_data[31:0], 32'h0);
    tick();
    idle();
    #1 check_all();
    check("r0_busy", 32'(busy_vec[0]), 32'h0);

    // Claim r3, then retire it with a write.
    claim = 1'b1; caddr = 5'd3;
    set_rd(3, 0);
    #1 check_all();
    check("claim_hidden", 32'(rd_busy[0]), 32'h0);
    tick();
    idle();
    #1 check_all();
    check("busy3", 32'(busy_vec[3]), 32'h1);
    check("cnt1", 32'(busy_cnt), 32'h1);
    check("rd_busy3", 32'(rd_busy[0]), 32'h1);
    set_wr(0, 3, 32'h0000CAFE);
    #1 check_all();
    check("wr_hides_busy", 32'(rd_busy[0]), 32'h0);
    tick();
    idle();
    #1 check_all();
    check("cnt0", 32'(busy_cnt), 32'h0);

    // Claim and write of r9 together leaves it busy.
    claim = 1'b1; caddr = 5'd9;
    set_wr(1, 9, 32'h99999999);
    set_rd(9, 3);
    #1 check_all();
    tick();
    idle();
    #1 check_all();
    check("busy9", 32'(busy_vec[9]), 32'h1);

    // Populate r1..r4, claim r2 and r4, then reset between edges.
    set_wr(0, 1, 32'hA1A1A1A1); set_wr(1, 2, 32'hA2A2A2A2);
    claim = 1'b1; caddr = 5'd2;
    #1 check_all();
    tick();
    idle();
    set_wr(0, 3, 32'hA3A3A3A3); set_wr(1, 4, 32'hA4A4A4A4);
    claim = 1'b1; caddr = 5'd4;
    set_rd(1, 2);
    #1 check_all();
    tick();
    idle();
    set_rd(2, 4);
    #1 check_all();
    check("cnt3", 32'(busy_cnt), 32'h3);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    check("midrst_r2", rd_data[31:0], 32'h0);
    check("midrst_vec", busy_vec, 32'h0);
    #1 rst_n = 1'b1;
    set_wr(0, 1, 32'h5A5A5A5A);
    set_rd(1, 3);
    #1 check_all();
    tick();
    idle();
    #1 check_all();
    check("post_rst_r1", rd_data[31:0], 32'h5A5A5A5A);

    // Random traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      we = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW] = AW'($urandom_range(0, (i % 3 == 0) ? 31 : 7));
        wd[j*DW +: DW] = $urandom;
      end
      claim = ($urandom_range(0, 2) == 0);
      caddr = AW'($urandom_range(0, 7));
      set_rd($urandom_range(0, 7), $urandom_range(0, 31));
      #1 check_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
